hamming16_sec_decoder: RTL and testbench
========================================

Name: hamming16_sec_decoder

Overview:
- Registered Hamming(21,16) single-error-correcting decoder with two independent decode channels sharing one clock.
- Channel A takes 16 data bits plus a separate 5-bit parity word. Channel B takes one packed 21-bit codeword.
- Each channel outputs the corrected 16-bit data and an error flag.
- Sits on the receive side of the storage/link path, after the matching Hamming encoder.

Parameters:
- None. Widths are fixed: 16 data bits, 5 parity bits, 21-bit codeword.

Ports:
- clk  in  1  clock; all registers update on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_valid_in  in  1  channel A input qualifier
- a_data_in  in  16  channel A received data
- a_parity_in  in  5  channel A received parity; bit i is the parity for syndrome bit i
- a_valid_out  out  1  channel A output qualifier
- a_data_out  out  16  channel A corrected data
- a_error_flag  out  1  channel A nonzero syndrome detected
- b_valid_in  in  1  channel B input qualifier
- b_code_in  in  21  channel B received codeword; bit k holds Hamming position k+1
- b_valid_out  out  1  channel B output qualifier
- b_data_out  out  16  channel B corrected data
- b_error_flag  out  1  channel B nonzero syndrome detected

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-low.
- Reset values: all valid_out, data_out and error_flag outputs are 0.
- Position map (positions 1..21):
  - Parity bits sit at positions 1, 2, 4, 8, 16.
  - Data bit d[n] occupies the n-th non-power-of-two position in ascending order: d0 at 3, d1 at 5, d2 at 6, d3 at 7, d4..d10 at 9..15, d11..d15 at 17..21.
- Parity rule: even parity. Parity bit i is the XOR of all data bits whose position has bit i set.
- Channel B packing: parity bits live at b_code_in indices 0, 1, 3, 7, 15. Data bits live at index (position - 1).
- Syndrome: 5 bits, equal to recomputed parity XOR received parity. Channel A takes received parity from a_parity_in; channel B extracts it from the codeword.
- Correction rules by syndrome value:
  - 0: data passes unchanged, flag = 0.
  - Equal to a data position (3..21, not a power of two): invert that data bit, flag = 1.
  - Power of two (1, 2, 4, 8, 16): the parity bit is in error; data unchanged, flag = 1.
  - 22..31 (invalid, multi-bit): data passes uncorrected, flag = 1.
- No double-error detection. A 2-bit error may miscorrect; that is required behaviour, not a fault.
- Latency: exactly 1 cycle. Inputs sampled on edge N appear on the outputs after edge N, with valid_out = 1 for that cycle.
- When valid_in = 0: valid_out goes to 0 on the next edge, and data_out and error_flag hold their previous values.
- Channels are fully independent. Simultaneous valid inputs on both channels are processed in the same cycle.
- Reset asserted mid-stream clears all outputs immediately. The first valid result after reset release appears one edge after the first sampled valid_in.
- Decode logic is purely combinational between the input pins and the output registers; there are no input registers.

Test Plan:
- No errors: A gets data 0xFFFF, parity 0x1E; B gets code 0x1FFFFE, both valid -> next cycle both data_out = 0xFFFF, flags = 0, valid_out = 1.
- Single data-bit error:
  - A gets data 0x0001 (d0 flipped from 0x0000), parity 0x00 -> data_out 0x0000, flag 1 (syndrome 3).
  - B gets 0x000004 (position 3 set on an all-zero codeword) -> data_out 0x0000, flag 1.
- Parity-bit error: B gets 0x1F7FFE (bit 15 of 0x1FFFFE flipped) -> data_out 0xFFFF, flag 1 (syndrome 16). A gets data 0xFFFF, parity 0x0E -> data_out 0xFFFF, flag 1.
- Exhaustive single flips: for 512 random words, flip each of A's 16 data bits and each of B's code bits 0..15 in turn -> data_out always equals the original data, flag 1, zero mismatches.
- Invalid and double errors:
  - A gets data 0x0000, parity 0x1F -> data_out 0x0000, flag 1 (syndrome 31, uncorrected).
  - A gets data 0x0003, parity 0x00 -> data_out 0x0007, flag 1 (miscorrection at position 6).
- Reset and valid handling:
  - Assert rst_n = 0 mid-stream -> all outputs 0 immediately.
  - Release, drive valid_in = 0 -> valid_out stays 0 and data_out stays 0.
  - Drive one valid word -> output appears exactly one cycle later.

Source files
------------

// File: rtl/hamming16_sec_decoder.sv
// rtl/hamming16_sec_decoder.sv - registered Hamming(21,16) single-error-correcting decoder, two channels
module hamming16_sec_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid_in,
    input  logic [15:0] a_data_in,
    input  logic [4:0]  a_parity_in,
    output logic        a_valid_out,
    output logic [15:0] a_data_out,
    output logic        a_error_flag,
    input  logic        b_valid_in,
    input  logic [20:0] b_code_in,
    output logic        b_valid_out,
    output logic [15:0] b_data_out,
    output logic        b_error_flag
);

    // Data bits fill the non-power-of-two positions in ascending order.
    function automatic logic [20:0] place_data(input logic [15:0] d);
        logic [20:0] cw;
        logic [3:0]  n;
        logic [4:0]  idx;
        cw = '0;
        n  = '0;
        for (int p = 1; p <= 21; p++) begin
            idx = 5'(p - 1);
            if ((p & (p - 1)) != 0) begin
                cw[idx] = d[n];
                n       = n + 4'd1;
            end
        end
        return cw;
    endfunction

    function automatic logic [15:0] extract_data(input logic [20:0] cw);
        logic [15:0] d;
        logic [3:0]  n;
        logic [4:0]  idx;
        d = '0;
        n = '0;
        for (int p = 1; p <= 21; p++) begin
            idx = 5'(p - 1);
            if ((p & (p - 1)) != 0) begin
                d[n] = cw[idx];
                n    = n + 4'd1;
            end
        end
        return d;
    endfunction

    function automatic logic [20:0] place_parity(input logic [4:0] par);
        logic [20:0] cw;
        cw     = '0;
        cw[0]  = par[0];
        cw[1]  = par[1];
        cw[3]  = par[2];
        cw[7]  = par[3];
        cw[15] = par[4];
        return cw;
    endfunction

    // XOR of the positions of all set bits: parity positions fold in the
    // received parity, so the result is recomputed XOR received.
    function automatic logic [4:0] syndrome_of(input logic [20:0] cw);
        logic [4:0] s;
        logic [4:0] idx;
        s = '0;
        for (int p = 1; p <= 21; p++) begin
            idx = 5'(p - 1);
            if (cw[idx]) begin
                s = s ^ 5'(p);
            end
        end
        return s;
    endfunction

    // Flipping a parity position is harmless since only data is extracted;
    // syndromes above 21 leave the word untouched.
    function automatic logic [20:0] correct(input logic [20:0] cw, input logic [4:0] syn);
        logic [20:0] fixed;
        logic [4:0]  idx;
        fixed = cw;
        idx   = syn - 5'd1;
        if (syn != 5'd0 && syn <= 5'd21) begin
            fixed[idx] = ~fixed[idx];
        end
        return fixed;
    endfunction

    logic [20:0] a_code;
    logic [4:0]  a_syn;
    logic [15:0] a_fixed;
    logic [4:0]  b_syn;
    logic [15:0] b_fixed;

    assign a_code  = place_data(a_data_in) | place_parity(a_parity_in);
    assign a_syn   = syndrome_of(a_code);
    assign a_fixed = extract_data(correct(a_code, a_syn));
    assign b_syn   = syndrome_of(b_code_in);
    assign b_fixed = extract_data(correct(b_code_in, b_syn));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_out  <= 1'b0;
            a_data_out   <= '0;
            a_error_flag <= 1'b0;
            b_valid_out  <= 1'b0;
            b_data_out   <= '0;
            b_error_flag <= 1'b0;
        end else begin
            a_valid_out <= a_valid_in;
            b_valid_out <= b_valid_in;
            if (a_valid_in) begin
                a_data_out   <= a_fixed;
                a_error_flag <= (a_syn != 5'd0);
            end
            if (b_valid_in) begin
                b_data_out   <= b_fixed;
                b_error_flag <= (b_syn != 5'd0);
            end
        end
    end

endmodule

// File: tb/tb_hamming16_sec_decoder.sv
// tb/tb_hamming16_sec_decoder.sv - scoreboard testbench for hamming16_sec_decoder
module tb_hamming16_sec_decoder;

    logic        clk;
    logic        rst_n;
    logic        a_valid_in;
    logic [15:0] a_data_in;
    logic [4:0]  a_parity_in;
    logic        a_valid_out;
    logic [15:0] a_data_out;
    logic        a_error_flag;
    logic        b_valid_in;
    logic [20:0] b_code_in;
    logic        b_valid_out;
    logic [15:0] b_data_out;
    logic        b_error_flag;

    hamming16_sec_decoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_valid_in   (a_valid_in),
        .a_data_in    (a_data_in),
        .a_parity_in  (a_parity_in),
        .a_valid_out  (a_valid_out),
        .a_data_out   (a_data_out),
        .a_error_flag (a_error_flag),
        .b_valid_in   (b_valid_in),
        .b_code_in    (b_code_in),
        .b_valid_out  (b_valid_out),
        .b_data_out   (b_data_out),
        .b_error_flag (b_error_flag)
    );

    typedef struct {
        logic [15:0] data;
        logic        flag;
        int          due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit peek(input int ch, output exp_t e);
        if (ch == 0) begin
            if (qa.size() == 0) return 1'b0;
            e = qa[0];
        end else begin
            if (qb.size() == 0) return 1'b0;
            e = qb[0];
        end
        return 1'b1;
    endfunction

    function automatic void drop(input int ch);
        if (ch == 0) void'(qa.pop_front());
        else         void'(qb.pop_front());
    endfunction

    task automatic mon(input int ch, input logic vo, input logic [15:0] d, input logic f);
        exp_t  e;
        bit    have;
        string nm;
        nm   = (ch == 0) ? "chan_a" : "chan_b";
        have = peek(ch, e);
        while (have && e.due < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s missing output: got none, required data %h flag %b at cycle %0d", nm, e.data, e.flag, e.due);
            drop(ch);
            have = peek(ch, e);
        end
        if (vo) begin
            n_checks++;
            if (!have) begin
                n_fail++;
                $display("FAIL %s unexpected valid_out at cycle %0d: got data %h flag %b, required no output", nm, cyc, d, f);
            end else if (e.due != cyc) begin
                n_fail++;
                $display("FAIL %s latency: got output at cycle %0d, required cycle %0d", nm, cyc, e.due);
                drop(ch);
            end else begin
                drop(ch);
                if (d !== e.data || f !== e.flag) begin
                    n_fail++;
                    $display("FAIL %s result at cycle %0d: got data %h flag %b, required data %h flag %b", nm, cyc, d, f, e.data, e.flag);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, a_valid_out, a_data_out, a_error_flag);
        mon(1, b_valid_out, b_data_out, b_error_flag);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic drive(input logic av, input logic [15:0] ad, input logic [4:0] ap,
                         input logic bv, input logic [20:0] bc,
                         input logic [15:0] ea, input logic fa,
                         input logic [15:0] eb, input logic fb, input bit push);
        exp_t e;
        @(posedge clk);
        #1;
        a_valid_in  = av;
        a_data_in   = ad;
        a_parity_in = ap;
        b_valid_in  = bv;
        b_code_in   = bc;
        if (push && av) begin
            e.data = ea; e.flag = fa; e.due = cyc + 1;
            qa.push_back(e);
        end
        if (push && bv) begin
            e.data = eb; e.flag = fb; e.due = cyc + 1;
            qb.push_back(e);
        end
    endtask

    function automatic void encode(input logic [15:0] d, output logic [4:0] p, output logic [20:0] c);
        int dpos[16] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19, 20, 21};
        p = '0;
        c = '0;
        for (int n = 0; n < 16; n++) begin
            if (d[n]) begin
                p = p ^ 5'(dpos[n]);
                c[dpos[n] - 1] = 1'b1;
            end
        end
        for (int i = 0; i < 5; i++) c[(1 << i) - 1] = p[i];
    endfunction

    initial begin
        logic [15:0] d;
        logic [4:0]  p;
        logic [20:0] c;
        logic [15:0] m16;
        logic [20:0] m21;

        rst_n = 1'b0;
        a_valid_in = 1'b0; a_data_in = '0; a_parity_in = '0;
        b_valid_in = 1'b0; b_code_in = '0;
        #3;
        chk("reset a_valid_out",  32'(a_valid_out),  32'd0);
        chk("reset a_data_out",   32'(a_data_out),   32'd0);
        chk("reset a_error_flag", 32'(a_error_flag), 32'd0);
        chk("reset b_valid_out",  32'(b_valid_out),  32'd0);
        chk("reset b_data_out",   32'(b_data_out),   32'd0);
        chk("reset b_error_flag", 32'(b_error_flag), 32'd0);
        #19 rst_n = 1'b1;

        drive(1, 16'hFFFF, 5'h1E, 1, 21'h1FFFFE, 16'hFFFF, 0, 16'hFFFF, 0, 1);
        drive(1, 16'h0001, 5'h00, 1, 21'h000004, 16'h0000, 1, 16'h0000, 1, 1);
        drive(1, 16'hFFFF, 5'h0E, 1, 21'h1F7FFE, 16'hFFFF, 1, 16'hFFFF, 1, 1);
        drive(1, 16'h0000, 5'h1F, 1, 21'h000000, 16'h0000, 1, 16'h0000, 0, 1);
        drive(1, 16'h0003, 5'h00, 1, 21'h000014, 16'h0007, 1, 16'h0007, 1, 1);
        drive(0, 16'h0000, 5'h00, 0, 21'h000000, 16'h0000, 0, 16'h0000, 0, 1);
        repeat (2) @(negedge clk);
        chk("idle a_valid_out",  32'(a_valid_out),  32'd0);
        chk("hold a_data_out",   32'(a_data_out),   32'h0007);
        chk("hold a_error_flag", 32'(a_error_flag), 32'd1);
        chk("idle b_valid_out",  32'(b_valid_out),  32'd0);
        chk("hold b_data_out",   32'(b_data_out),   32'h0007);

        for (int w = 0; w < 512; w++) begin
            d = 16'($urandom);
            encode(d, p, c);
            for (int b = 0; b < 16; b++) begin
                m16 = 16'd1 << b;
                m21 = 21'd1 << b;
                drive(1, d ^ m16, p, 1, c ^ m21, d, 1, d, 1, 1);
            end
        end

        drive(1, 16'hFFFF, 5'h1E, 1, 21'h1FFFFE, 16'hFFFF, 0, 16'hFFFF, 0, 1);
        drive(1, 16'h5555, 5'h00, 1, 21'h0AAAAA, 16'h0000, 0, 16'h0000, 0, 0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset a_valid_out",  32'(a_valid_out),  32'd0);
        chk("async reset a_data_out",   32'(a_data_out),   32'd0);
        chk("async reset a_error_flag", 32'(a_error_flag), 32'd0);
        chk("async reset b_valid_out",  32'(b_valid_out),  32'd0);
        chk("async reset b_data_out",   32'(b_data_out),   32'd0);
        chk("async reset b_error_flag", 32'(b_error_flag), 32'd0);
        a_valid_in = 1'b0;
        b_valid_in = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post-reset a_valid_out", 32'(a_valid_out), 32'd0);
            chk("post-reset a_data_out",  32'(a_data_out),  32'd0);
            chk("post-reset b_valid_out", 32'(b_valid_out), 32'd0);
            chk("post-reset b_data_out",  32'(b_data_out),  32'd0);
        end
        drive(1, 16'h0001, 5'h03, 1, 21'h000007, 16'h0001, 0, 16'h0001, 0, 1);
        drive(0, 16'h0000, 5'h00, 0, 21'h000000, 16'h0000, 0, 16'h0000, 0, 1);
        repeat (3) @(negedge clk);
        chk("chan_a queue drained", 32'(qa.size()), 32'd0);
        chk("chan_b queue drained", 32'(qb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
